// File: rtl/ring_pkg.sv
// ring_pkg: slot-type constants and arbiter state encoding shared by ring stations
// Contents: NULL_SLOT, TOKEN_SLOT, MESSAGE_SLOT slot-type codes; arbState_t FSM states.
package ring_pkg;

    localparam logic [3:0] NULL_SLOT    = 4'd7;
    localparam logic [3:0] TOKEN_SLOT   = 4'd1;
    localparam logic [3:0] MESSAGE_SLOT = 4'd8;

    typedef enum logic [1:0] {IDLE, WAIT_TRAIN, SEND} arbState_t;

endpackage

// File: rtl/ring_slot_arbiter_if.sv
// ring_slot_arbiter_if: ring and requester signals of one ring slot arbiter
// Ring side: RingIn/SlotTypeIn/SrcDestIn in; arbRingOut/arbSlotTypeOut/arbSrcDestOut/arbDriveRing out.
// Requester side: req/reqLen/reqDest/reqData in; pop/done/grant out (per requester, N wide).
// master = the arbiter, slave = ring input plus the requesters.
interface ring_slot_arbiter_if #(parameter int N = 3);

    logic [31:0]     RingIn;
    logic [3:0]      SlotTypeIn;
    logic [3:0]      SrcDestIn;
    logic [N-1:0]    req;
    logic [6*N-1:0]  reqLen;
    logic [4*N-1:0]  reqDest;
    logic [32*N-1:0] reqData;
    logic [N-1:0]    pop;
    logic [N-1:0]    done;
    logic [N-1:0]    grant;
    logic [31:0]     arbRingOut;
    logic [3:0]      arbSlotTypeOut;
    logic [3:0]      arbSrcDestOut;
    logic            arbDriveRing;

    modport master (
        input  RingIn, SlotTypeIn, SrcDestIn, req, reqLen, reqDest, reqData,
        output pop, done, grant, arbRingOut, arbSlotTypeOut, arbSrcDestOut, arbDriveRing
    );

    modport slave (
        output RingIn, SlotTypeIn, SrcDestIn, req, reqLen, reqDest, reqData,
        input  pop, done, grant, arbRingOut, arbSlotTypeOut, arbSrcDestOut, arbDriveRing
    );

endinterface

// File: rtl/ring_slot_arbiter_rr_pick.sv
// rr_pick: N-wide round-robin select, first requester strictly after ptr (wrapping)
// Ports: req (N) and ptr (index of last winner) in; winner (one-hot), index, valid out.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] index,
    output logic          valid
);

    logic [IW-1:0] j;

    always_comb begin
        index = '0;
        valid = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!valid && req[j]) begin
                valid = 1'b1;
                index = j;
            end
        end
        winner = valid ? (N'(1) << index) : '0;
    end

endmodule

// File: rtl/ring_slot_arbiter.sv
// ring_slot_arbiter: shares this core's ring transmit port among N senders, one burst per token
// Ports: clock, reset (sync, active-high), whichCore (reserved, unused),
//        bus (ring_slot_arbiter_if.master: ring in/out plus per-requester req/len/dest/data, pop/done/grant).
module ring_slot_arbiter
    import ring_pkg::*;
#(
    parameter int N = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] whichCore,
    ring_slot_arbiter_if.master bus
);

    localparam int IW = $clog2(N);

    arbState_t     state, nextState;
    logic [IW-1:0] rrPtr, winReg, pickIdx;
    logic [N-1:0]  pickHot, grantReg, winHot;
    logic          pickValid, tokenGrant, lastWord;
    logic [7:0]    trainCnt;
    logic [6:0]    wordCnt;
    logic [3:0]    destReg;
    logic [8:0]    newCount;
    logic          unusedWhichCore;

    assign unusedWhichCore = ^whichCore;

    rr_pick #(.N(N)) picker (
        .req    (bus.req),
        .ptr    (rrPtr),
        .winner (pickHot),
        .index  (pickIdx),
        .valid  (pickValid)
    );

    // 9-bit sum so a train that would exceed 255 slots is detected and refused
    assign newCount   = {1'b0, bus.RingIn[7:0]} + {3'b0, bus.reqLen[int'(pickIdx)*6 +: 6]} + 9'd1;
    assign tokenGrant = state == IDLE && bus.SlotTypeIn == TOKEN_SLOT && pickValid && !newCount[8];
    assign lastWord   = state == SEND && wordCnt == 7'd1;
    assign winHot     = N'(1) << winReg;
    assign bus.grant  = grantReg | (tokenGrant ? pickHot : '0);

    always_comb begin
        nextState          = state;
        bus.arbRingOut     = bus.RingIn;
        bus.arbSlotTypeOut = bus.SlotTypeIn;
        bus.arbSrcDestOut  = bus.SrcDestIn;
        bus.arbDriveRing   = 1'b0;
        bus.pop            = '0;
        bus.done           = '0;
        case (state)
            IDLE: begin
                if (tokenGrant) begin
                    bus.arbRingOut   = {bus.RingIn[31:8], newCount[7:0]};
                    bus.arbDriveRing = 1'b1;
                    nextState        = bus.RingIn[7:0] == 8'd0 ? SEND : WAIT_TRAIN;
                end
            end
            WAIT_TRAIN: nextState = trainCnt == 8'd1 ? SEND : WAIT_TRAIN;
            SEND: begin
                bus.arbRingOut     = bus.reqData[int'(winReg)*32 +: 32];
                bus.arbSlotTypeOut = MESSAGE_SLOT;
                bus.arbSrcDestOut  = destReg;
                bus.arbDriveRing   = 1'b1;
                bus.pop            = winHot;
                bus.done           = lastWord ? winHot : '0;
                nextState          = lastWord ? IDLE : SEND;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rrPtr    <= IW'(N - 1);
            winReg   <= '0;
            grantReg <= '0;
            trainCnt <= '0;
            wordCnt  <= '0;
            destReg  <= '0;
        end else begin
            state <= nextState;
            if (tokenGrant) begin
                winReg   <= pickIdx;
                rrPtr    <= pickIdx;
                grantReg <= pickHot;
                trainCnt <= bus.RingIn[7:0];
                wordCnt  <= {1'b0, bus.reqLen[int'(pickIdx)*6 +: 6]} + 7'd1;
                destReg  <= bus.reqDest[int'(pickIdx)*4 +: 4];
            end else if (state == WAIT_TRAIN) begin
                trainCnt <= trainCnt - 8'd1;
            end else if (state == SEND) begin
                wordCnt  <= wordCnt - 7'd1;
                grantReg <= lastWord ? '0 : grantReg;
            end
        end
    end

endmodule
